// File: rtl/fmul_arbiter_pkg.sv
// Shared FPU definitions used by the fmul arbiter: multiplier latency, tag layout.
package fmul_arbiter_pkg;

  localparam int FMUL_LATENCY = 2;
  localparam int DATA_W       = 32;
  localparam int TAG_ID_W     = 3;
  localparam int MAX_REQ      = 8;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } fmul_tag_t;

  localparam fmul_tag_t TAG_IDLE = '{valid: 1'b0, id: '0};

endpackage

// File: rtl/fmul_arbiter_rr.sv
// Combinational N-way round-robin picker: first request strictly after `last`, wrapping.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_any
);

  logic hi_hit;

  // Two passes: indices above `last` win; otherwise wrap to the lowest requester.
  always_comb begin
    hi_hit  = 1'b0;
    gnt_idx = '0;
    gnt_any = |req;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i] && (IDX_W'(i) > last)) begin
        hi_hit  = 1'b1;
        gnt_idx = IDX_W'(i);
      end
    end
    if (!hi_hit) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (req[i]) gnt_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    gnt = '0;
    for (int i = 0; i < N; i++) begin
      gnt[i] = gnt_any && (gnt_idx == IDX_W'(i));
    end
  end

endmodule

// File: rtl/fmul_arbiter.sv
// Round-robin sharing of one pipelined fmul between N_REQ requesters, with a tag
// pipeline routing products back. Optional counters under FMUL_ARB_PERF_EN.
module fmul_arbiter
  import fmul_arbiter_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int LATENCY = FMUL_LATENCY
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [DATA_W*N_REQ-1:0] req_x1,
  input  logic [DATA_W*N_REQ-1:0] req_x2,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]       rsp_y,
  output logic [DATA_W-1:0]       mul_x1,
  output logic [DATA_W-1:0]       mul_x2,
  input  logic [DATA_W-1:0]       mul_y,
  output logic                    busy
`ifdef FMUL_ARB_PERF_EN
  ,
  output logic [31:0]             perf_issue,
  output logic [31:0]             perf_conflict
`endif
);

  localparam int IDX_W = $clog2(N_REQ);

  logic [N_REQ-1:0] req_act;
  logic [N_REQ-1:0] gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic [IDX_W-1:0] last_q;
  logic             xfer;
  fmul_tag_t        tag_p [LATENCY];

  // Requests are masked while reset is held so no grant is visible then.
  assign req_act = rst ? '0 : req_valid;

  rr_arbiter #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req     (req_act),
    .last    (last_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (xfer)
  );

  assign req_ready = gnt;

  always_comb begin
    mul_x1 = '0;
    mul_x2 = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        mul_x1 = req_x1[i*DATA_W +: DATA_W];
        mul_x2 = req_x2[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= IDX_W'(N_REQ - 1);
    end else if (xfer) begin
      last_q <= gnt_idx;
    end
  end

  // Issue -> p0 ... p(LATENCY-1): shifts unconditionally in lock-step with fmul.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < LATENCY; s++) tag_p[s] <= TAG_IDLE;
    end else begin
      tag_p[0] <= '{valid: xfer, id: TAG_ID_W'(gnt_idx)};
      for (int s = 1; s < LATENCY; s++) tag_p[s] <= tag_p[s-1];
    end
  end

  // Final stage: strobe the issuer, product passes straight through.
  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rsp_valid[i] = tag_p[LATENCY-1].valid && (tag_p[LATENCY-1].id == TAG_ID_W'(i));
    end
  end

  assign rsp_y = mul_y;

  always_comb begin
    busy = 1'b0;
    for (int s = 0; s < LATENCY; s++) busy = busy | tag_p[s].valid;
  end

`ifdef FMUL_ARB_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  logic multi_req;
  assign multi_req = |(req_valid & (req_valid - N_REQ'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_issue    <= '0;
      perf_conflict <= '0;
    end else begin
      if (xfer)      perf_issue    <= sat_inc(perf_issue);
      if (multi_req) perf_conflict <= sat_inc(perf_conflict);
    end
  end
`endif

endmodule

// File: tb/tb_fmul_arbiter.sv
// Bench for fmul_arbiter: table vectors, hand sequences and randomized traffic vs a
// scoreboard model. Build with FMUL_ARB_PERF_EN to also check the counters.
module tb_fmul_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]   req_valid = '0;
  logic [1:0]   req_ready, rsp_valid;
  logic [63:0]  req_x1 = '0, req_x2 = '0;
  logic [31:0]  rsp_y, mul_x1, mul_x2, mul_y;
  logic         busy;

  logic [3:0]   rv4 = '0;
  logic [3:0]   ready4, rsp4;
  logic [127:0] x4a, x4b;
  logic [31:0]  y4, m4x1, m4x2, m4y;
  logic         busy4;

`ifdef FMUL_ARB_PERF_EN
  logic [31:0] perf_issue, perf_conflict, perf4_issue, perf4_conflict;
`endif

  fmul_arbiter #(.N_REQ(2), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_x1(req_x1), .req_x2(req_x2), .rsp_valid(rsp_valid), .rsp_y(rsp_y),
    .mul_x1(mul_x1), .mul_x2(mul_x2), .mul_y(mul_y), .busy(busy)
`ifdef FMUL_ARB_PERF_EN
    , .perf_issue(perf_issue), .perf_conflict(perf_conflict)
`endif
  );

  fmul_arbiter #(.N_REQ(4), .LATENCY(2)) dut4 (
    .clk(clk), .rst(rst), .req_valid(rv4), .req_ready(ready4),
    .req_x1(x4a), .req_x2(x4b), .rsp_valid(rsp4), .rsp_y(y4),
    .mul_x1(m4x1), .mul_x2(m4x2), .mul_y(m4y), .busy(busy4)
`ifdef FMUL_ARB_PERF_EN
    , .perf_issue(perf4_issue), .perf_conflict(perf4_conflict)
`endif
  );

  // Truncating single-precision multiply for normal operands (stand-in fmul).
  function automatic logic [31:0] fmul_model(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] m;
    logic [9:0]  e;
    logic [22:0] f;
    m = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127;
    if (m[47]) begin
      f = m[46:24];
      e = e + 10'd1;
    end else begin
      f = m[45:23];
    end
    return {a[31] ^ b[31], e[7:0], f};
  endfunction

  function automatic logic [31:0] rand_fp();
    return {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
  endfunction

  // Two-cycle multiplier stand-ins.
  logic [31:0] s1, s2, s41, s42;
  always_ff @(posedge clk) begin
    s1  <= fmul_model(mul_x1, mul_x2);
    s2  <= s1;
    s41 <= fmul_model(m4x1, m4x2);
    s42 <= s41;
  end
  assign mul_y = s2;
  assign m4y   = s42;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: last granted index and expected strobes keyed by absolute cycle.
  int          m_last = 1;
  logic [1:0]  pend_v [int];
  logic [31:0] pend_y [int];

  logic [1:0]  obs_ready, obs_rsp;
  logic [31:0] obs_y, obs_mx1;
  logic        obs_busy;
  logic [3:0]  obs4_ready, obs4_rsp;
  logic [31:0] obs4_y;

  task automatic step(input logic [1:0] rv, input logic [63:0] x1, input logic [63:0] x2);
    int         gi;
    int         c;
    logic [1:0] g;
    logic [1:0] er;
    logic       eb;
    req_valid = rv;
    req_x1    = x1;
    req_x2    = x2;
    if (rst) begin
      pend_v.delete();
      pend_y.delete();
      m_last = 1;
    end
    gi = -1;
    if (!rst) begin
      for (int k = 1; k <= 2; k++) begin
        c = (m_last + k) % 2;
        if (gi < 0 && rv[c]) gi = c;
      end
    end
    g = '0;
    if (gi >= 0) g[gi] = 1'b1;
    er = pend_v.exists(cyc) ? pend_v[cyc] : 2'b00;
    eb = pend_v.exists(cyc) || pend_v.exists(cyc + 1);
    @(negedge clk);
    obs_ready  = req_ready;
    obs_rsp    = rsp_valid;
    obs_y      = rsp_y;
    obs_mx1    = mul_x1;
    obs_busy   = busy;
    obs4_ready = ready4;
    obs4_rsp   = rsp4;
    obs4_y     = y4;
    chk("ready", 64'(req_ready), 64'(g));
    chk("mul_x1", 64'(mul_x1), (gi >= 0) ? 64'(x1[gi*32 +: 32]) : 64'd0);
    chk("mul_x2", 64'(mul_x2), (gi >= 0) ? 64'(x2[gi*32 +: 32]) : 64'd0);
    chk("rsp_valid", 64'(rsp_valid), 64'(er));
    if (er != 2'b00) chk("rsp_y", 64'(rsp_y), 64'(pend_y[cyc]));
    chk("busy", 64'(busy), 64'(eb));
    @(posedge clk);
    if (!rst && gi >= 0) begin
      m_last           = gi;
      pend_v[cyc + 2]  = g;
      pend_y[cyc + 2]  = fmul_model(x1[gi*32 +: 32], x2[gi*32 +: 32]);
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(2'b00, 64'd0, 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2'b11, 64'd0, 64'd0);
    chk("rst_ready", 64'(obs_ready), 64'd0);
    chk("rst_busy", 64'(obs_busy), 64'd0);
    chk("rst_rsp", 64'(obs_rsp), 64'd0);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [1:0] rv;
    logic [1:0] ready;
    logic [1:0] rsp;
    logic       busy;
  } vec_t;

  vec_t       tbl [12];
  logic [3:0] s4_rv  [7];
  logic [3:0] s4_rdy [7];
  logic [3:0] s4_rsp [7];

  initial begin
    tbl[0]  = '{2'b11, 2'b01, 2'b00, 1'b0};
    tbl[1]  = '{2'b11, 2'b10, 2'b00, 1'b1};
    tbl[2]  = '{2'b11, 2'b01, 2'b01, 1'b1};
    tbl[3]  = '{2'b11, 2'b10, 2'b10, 1'b1};
    tbl[4]  = '{2'b11, 2'b01, 2'b01, 1'b1};
    tbl[5]  = '{2'b11, 2'b10, 2'b10, 1'b1};
    tbl[6]  = '{2'b10, 2'b10, 2'b01, 1'b1};
    tbl[7]  = '{2'b10, 2'b10, 2'b10, 1'b1};
    tbl[8]  = '{2'b10, 2'b10, 2'b10, 1'b1};
    tbl[9]  = '{2'b00, 2'b00, 2'b10, 1'b1};
    tbl[10] = '{2'b00, 2'b00, 2'b10, 1'b1};
    tbl[11] = '{2'b00, 2'b00, 2'b00, 1'b0};

    s4_rv  = '{4'b0100, 4'b1101, 4'b1101, 4'b1101, 4'b1101, 4'b0000, 4'b0000};
    s4_rdy = '{4'b0100, 4'b1000, 4'b0001, 4'b0100, 4'b1000, 4'b0000, 4'b0000};
    s4_rsp = '{4'b0000, 4'b0000, 4'b0100, 4'b1000, 4'b0001, 4'b0100, 4'b1000};

    x4a = {32'h40400000, 32'h3F800000, 32'h41200000, 32'h3FC00000};
    x4b = {32'h40000000, 32'h40A00000, 32'h3F000000, 32'h40000000};

    #1;
    do_reset();
    do_reset();

    // Two requesters contending, then requester 1 alone for three cycles.
    for (int k = 0; k < 12; k++) begin
`ifdef FMUL_ARB_PERF_EN
      if (k == 6) begin
        chk("perf_issue", 64'(perf_issue), 64'd6);
        chk("perf_conflict", 64'(perf_conflict), 64'd6);
      end
`endif
      step(tbl[k].rv, {rand_fp(), rand_fp()}, {rand_fp(), rand_fp()});
      chk("tbl_ready", 64'(obs_ready), 64'(tbl[k].ready));
      chk("tbl_rsp", 64'(obs_rsp), 64'(tbl[k].rsp));
      chk("tbl_busy", 64'(obs_busy), 64'(tbl[k].busy));
    end

    // Single request issued five cycles after reset.
    do_reset();
    idle(5);
    step(2'b01, {32'h0, 32'h3FC00000}, {32'h0, 32'h40000000});
    chk("single_mx1", 64'(obs_mx1), 64'h3FC00000);
    step(2'b00, 64'd0, 64'd0);
    chk("single_busy6", 64'(obs_busy), 64'd1);
    chk("single_rsp6", 64'(obs_rsp), 64'd0);
    step(2'b00, 64'd0, 64'd0);
    chk("single_rsp7", 64'(obs_rsp), 64'b01);
    chk("single_y7", 64'(obs_y), 64'h40400000);
    chk("single_busy7", 64'(obs_busy), 64'd1);
    step(2'b00, 64'd0, 64'd0);
    chk("single_busy8", 64'(obs_busy), 64'd0);

    // Reset one cycle after an issue drops the in-flight tag.
    step(2'b01, {rand_fp(), rand_fp()}, {rand_fp(), rand_fp()});
    rst = 1'b1;
    step(2'b11, 64'd0, 64'd0);
    chk("midrst_ready", 64'(obs_ready), 64'd0);
    chk("midrst_busy", 64'(obs_busy), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(2'b00, 64'd0, 64'd0);
      chk("midrst_rsp", 64'(obs_rsp), 64'd0);
    end

    // Four requesters: move last to 2, then 0/2/3 contend.
    for (int k = 0; k < 7; k++) begin
      rv4 = s4_rv[k];
      step(2'b00, 64'd0, 64'd0);
      chk("n4_ready", 64'(obs4_ready), 64'(s4_rdy[k]));
      chk("n4_rsp", 64'(obs4_rsp), 64'(s4_rsp[k]));
      for (int i = 0; i < 4; i++) begin
        if (s4_rsp[k][i]) chk("n4_y", 64'(obs4_y), 64'(fmul_model(x4a[i*32 +: 32], x4b[i*32 +: 32])));
      end
    end
    rv4 = '0;

    // Randomized traffic with occasional asynchronous resets.
    for (int k = 0; k < 400; k++) begin
      rst = ($urandom_range(0, 60) == 0);
      step(2'($urandom), {rand_fp(), rand_fp()}, {rand_fp(), rand_fp()});
    end
    rst = 1'b0;
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
